// File: rtl/dense_activation_stage.sv
// rtl/dense_activation_stage.sv - capture neuron results, activate, round/saturate, queue on a valid/ready stream
module dense_activation_stage #(
   parameter int OUT_W       = 16,
   parameter int DEPTH       = 4,
   parameter int NUM_NEURONS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [31:0]      in_data,
   input  logic                    in_done,
   input  logic [1:0]              act_mode,
   input  logic [4:0]              shift,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [CW-1:0]     CNT_MAX  = CW'(NUM_NEURONS - 1);
   localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
   localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

   logic                    done_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q, count_d;
   logic [OUT_W:0]          hold_q, hold_d;
   logic                    ovf_q, ovf_d;
   logic [OUT_W:0]          mem_q [DEPTH];

   logic signed [31:0]      act;
   logic signed [32:0]      act_w, rnd, scaled;
   logic signed [OUT_W-1:0] sat;
   logic [OUT_W:0]          new_entry, head;
   logic                    capture, full, pop, push;

   // Activation, round-half-up shift and saturation of the raw core result
   always_comb begin
      act = in_data;
      if (act_mode == 2'd1 && in_data < 0)
         act = '0;
      else if (act_mode == 2'd2 && in_data < 0)
         act = in_data >>> 3;
      act_w  = {act[31], act};
      rnd    = '0;
      scaled = act_w;
      if (shift != 5'd0) begin
         rnd    = 33'sd1 <<< (shift - 5'd1);
         scaled = (act_w + rnd) >>> shift;
      end
      if (scaled > SAT_MAX)
         sat = SAT_MAX[OUT_W-1:0];
      else if (scaled < SAT_MIN)
         sat = SAT_MIN[OUT_W-1:0];
      else
         sat = scaled[OUT_W-1:0];
      new_entry = {sat, cnt_q == CNT_MAX};
   end

   always_comb begin
      capture  = in_done & ~done_q;
      full     = (count_q == FULL_CNT);
      pop      = (count_q != '0) & out_ready;
      // A full FIFO still accepts when its head leaves in the same cycle
      push     = capture & (~full | pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
      if (capture)
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      else
         cnt_d = cnt_q;
      ovf_d  = ovf_q | (capture & full & ~pop);
      hold_d = pop ? mem_q[rd_ptr_q] : hold_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q   <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         done_q   <= in_done;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= new_entry;
   end

   // While empty, the last popped entry stays on the outputs
   assign head      = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
   assign out_data  = head[OUT_W:1];
   assign out_last  = head[0];
   assign out_valid = (count_q != '0);
   assign overflow  = ovf_q;

endmodule

// File: doc/dense_activation_stage.md
# dense_activation_stage

Downstream companion of the dense neuron core. It watches the core's `neuron_output`/`done` pair and captures exactly one result per completed evaluation. Each captured result passes through a selectable activation (pass, ReLU, leaky ReLU), a rounding arithmetic right shift and saturation to `OUT_W` bits. Results are queued in a small FIFO and presented on a valid/ready stream for the next layer, with a `last` tag every `NUM_NEURONS` results.

## Interface
- `OUT_W`, 16: signed output width, 8..32.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `NUM_NEURONS`, 4: results per layer; sets `out_last` cadence, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 32 signed: neuron core result.
- `in_done` in 1: core done flag. It is level-high while the result is valid and is cleared by the core's `start`.
- `act_mode` in 2: 0 = pass, 1 = ReLU, 2 = leaky (negative values `>>>3`), 3 = same as pass.
- `shift` in 5: right-shift amount, 0..31.
- `out_data` out `OUT_W` signed: head-of-FIFO value.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts when high with `out_valid`.
- `out_last` out 1: head entry is the `NUM_NEURONS`-th result of a layer.
- `overflow` out 1: sticky; a capture was dropped because the FIFO was full.

## Operation
- **Capture.** `done_q` registers `in_done`. A capture event occurs in any cycle where `in_done=1 && done_q=0`.
  - `in_done` held high produces no further captures.
  - A new capture requires `in_done` to go low and then high again.
- **Activation** (combinational, 32-bit signed `x = in_data`):
  - pass/3: `a = x`.
  - ReLU: `a = (x<0) ? 0 : x`.
  - leaky: `a = (x<0) ? x>>>3 : x`, arithmetic, floor.
- **Scale.** Widen to 33 bits.
  - If `shift>0`: `s = (a + (1<<(shift-1))) >>> shift`, i.e. round half up.
  - Else `s = a`.
- **Saturate.**
  - `s > 2^(OUT_W-1)-1` → max.
  - `s < -2^(OUT_W-1)` → min.
  - Otherwise truncate to `OUT_W`.
- **Layer tag.** Neuron counter `cnt`, 0..`NUM_NEURONS-1`.
  - Every capture event, accepted or dropped, stores `last = (cnt==NUM_NEURONS-1)` with the entry and advances `cnt`.
  - `cnt` wraps to 0 after `NUM_NEURONS-1`.
- **FIFO.** `{data,last}` entries, show-ahead.
  - Push on capture if not full, or if full and a pop occurs in the same cycle.
  - Pop when `out_valid && out_ready`.
  - Capture while full with no pop: entry dropped, `overflow` set.
- **Overflow.** `overflow` clears only on reset.
- **Output order.** Strictly capture order.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `overflow=0`.
  - `cnt=0`, `done_q=0`, FIFO empty.
- **Latency.**
  - Capture sampled at edge T.
  - Entry written at edge T; `out_valid`/`out_data` visible after edge T (cycle T+1).
  - `act_mode` and `shift` are sampled at the capture edge only.
- **Throughput.** Peak one push and one pop per cycle. Captures are at most one per 2 cycles due to the edge detect.
- **Simultaneous push and pop:**
  - When empty: the push lands and `out_valid` stays 0 that cycle, since there is nothing to pop.
  - When full: both succeed and occupancy is unchanged.
- **Output when empty.** `out_data`/`out_last` hold the last popped value. Consumers ignore them while `out_valid=0`.
- **Reset mid-operation.** All state clears asynchronously; in-flight and queued results are lost.
  - If `in_done` is high when reset releases, `done_q=0` means the first clock counts as a capture event.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with 2 entries queued → `out_valid=0`, `overflow=0`, `out_last=0` immediately; after release, the next capture is tagged as neuron 0.
- **ReLU/rounding** (`OUT_W=16`, mode 1): `in_data=-100` → 0; `1000`, shift 2 → 250; `1001`, shift 1 → 501; `-3`, mode 0, shift 1 → -1. Each appears one cycle after its `in_done` rising edge.
- **Saturation:** mode 0, shift 0: `0x7FFF_FFFF` → 32767; `0x8000_0000` → -32768. Shift 16, `0x7FFF_FFFF` → 32767 (rounded 32768 saturates).
- **Leaky:** mode 2, shift 0: `-80` → -10; `-81` → -11; `80` → 80.
- **Backpressure/overflow** (`DEPTH=4`, `NUM_NEURONS=4`): `out_ready=0`, five captures of 1..5 → `overflow=1`. Then drain 1,2,3,4 with `out_last` only on 4. The next capture 6 is tagged `last=0` as neuron 1, because the dropped 5 advanced `cnt`.
- **Level-held done and full-with-pop:** `in_done` held high 10 cycles → exactly one entry. With the FIFO full, a capture coincident with a pop → accepted, `overflow` stays 0.
